// File: rtl/bus_hold_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_hold_arbiter
// Brief    : Round-robin sharing of the 8088 local bus between NREQ masters
//            via HOLD/HLDA. Optional grant-tenure limit: HOLD_TENURE_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_hold_arbiter #(
    parameter int NREQ       = 2,
    parameter int MAX_TENURE = 16
) (
    input  logic                                     CLK,
    input  logic                                     RESET,
    input  logic [NREQ-1:0]                          REQ,
    input  logic                                     HLDA,
    output logic                                     HOLD,
    output logic [NREQ-1:0]                          GNT,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] OWNER,
    output logic                                     BUS_LOST
);

    localparam int             c_ow   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_ow:0]  c_nreq = (c_ow+1)'(NREQ);

    if ((NREQ < 1) || (NREQ > 8) || (MAX_TENURE < 2) || (MAX_TENURE > 255)) begin : g_param_check
        $error("bus_hold_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD_WAIT = 3'd1,
        ST_GRANT     = 3'd2,
        ST_HANDOFF   = 3'd3,
        ST_RELEASE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              hold_q, hold_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [c_ow-1:0]   owner_q, owner_d;
    logic [c_ow-1:0]   ptr_q, ptr_d;
    logic              lost_q, lost_d;

    logic              w_pick_found;
    logic [c_ow-1:0]   w_pick_idx;
    logic              w_others;

    function automatic logic [c_ow-1:0] next_idx(input logic [c_ow-1:0] idx);
        logic [c_ow:0] sum;
        sum = {1'b0, idx} + (c_ow+1)'(1);
        if (sum >= c_nreq) begin
            sum = sum - c_nreq;
        end
        return sum[c_ow-1:0];
    endfunction

    // First asserted request at or after the pointer, wrapping at NREQ-1.
    always_comb begin
        logic [c_ow-1:0] idx;
        idx          = ptr_q;
        w_pick_found = 1'b0;
        w_pick_idx   = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_pick_found && REQ[idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = idx;
            end
            idx = next_idx(idx);
        end
    end

    assign w_others = |(REQ & ~gnt_q);

`ifdef HOLD_TENURE_LIMIT_EN
    localparam logic [7:0] c_tenure_last = 8'(MAX_TENURE - 1);
    logic [7:0] tcnt_q, tcnt_d;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        lost_d  = 1'b0;
`ifdef HOLD_TENURE_LIMIT_EN
        tcnt_d  = tcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                hold_d = 1'b0;
                gnt_d  = '0;
                if (|REQ) begin
                    hold_d  = 1'b1;
                    state_d = ST_HOLD_WAIT;
                end
            end
            ST_HOLD_WAIT, ST_HANDOFF: begin
                gnt_d = '0;
                if (HLDA && w_pick_found) begin
                    gnt_d             = '0;
                    gnt_d[w_pick_idx] = 1'b1;
                    owner_d           = w_pick_idx;
                    state_d           = ST_GRANT;
`ifdef HOLD_TENURE_LIMIT_EN
                    tcnt_d            = 8'd0;
`endif
                end else if ((state_q == ST_HANDOFF) || !(|REQ)) begin
                    hold_d  = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_GRANT: begin
`ifdef HOLD_TENURE_LIMIT_EN
                tcnt_d = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
`endif
                // Losing HLDA wins over a simultaneous request drop.
                if (!HLDA) begin
                    gnt_d   = '0;
                    hold_d  = 1'b0;
                    lost_d  = 1'b1;
                    state_d = ST_RELEASE;
                end else if (!REQ[owner_q]) begin
                    gnt_d = '0;
                    ptr_d = next_idx(owner_q);
                    if (w_others) begin
                        state_d = ST_HANDOFF;
                    end else begin
                        hold_d  = 1'b0;
                        state_d = ST_RELEASE;
                    end
                end
`ifdef HOLD_TENURE_LIMIT_EN
                // >= so a competitor arriving after saturation still preempts.
                else if ((tcnt_q >= c_tenure_last) && w_others) begin
                    gnt_d   = '0;
                    ptr_d   = next_idx(owner_q);
                    state_d = ST_HANDOFF;
                end
`endif
            end
            ST_RELEASE: begin
                hold_d = 1'b0;
                gnt_d  = '0;
                if (!HLDA) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                hold_d  = 1'b0;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            lost_q  <= lost_d;
        end
    end

`ifdef HOLD_TENURE_LIMIT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tcnt_q <= 8'd0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`endif

    assign HOLD     = hold_q;
    assign GNT      = gnt_q;
    assign OWNER    = owner_q;
    assign BUS_LOST = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_hold_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_hold_arbiter
// Brief    : Directed vector table plus hand sequences for bus_hold_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_hold_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: NREQ=2, vector table
    logic       a_rst, a_hlda, a_hold, a_lost;
    logic [1:0] a_req, a_gnt;
    logic [0:0] a_owner;
    // DUT B: NREQ=4, round-robin order
    logic       b_rst, b_hlda, b_hold, b_lost;
    logic [3:0] b_req, b_gnt;
    logic [1:0] b_owner;
    // DUT C: NREQ=2, MAX_TENURE=4
    logic       c_rst, c_hlda, c_hold, c_lost;
    logic [1:0] c_req, c_gnt;
    logic [0:0] c_owner;

    bus_hold_arbiter #(.NREQ(2), .MAX_TENURE(16)) u_a (
        .CLK(clk), .RESET(a_rst), .REQ(a_req), .HLDA(a_hlda),
        .HOLD(a_hold), .GNT(a_gnt), .OWNER(a_owner), .BUS_LOST(a_lost));
    bus_hold_arbiter #(.NREQ(4), .MAX_TENURE(16)) u_b (
        .CLK(clk), .RESET(b_rst), .REQ(b_req), .HLDA(b_hlda),
        .HOLD(b_hold), .GNT(b_gnt), .OWNER(b_owner), .BUS_LOST(b_lost));
    bus_hold_arbiter #(.NREQ(2), .MAX_TENURE(4)) u_c (
        .CLK(clk), .RESET(c_rst), .REQ(c_req), .HLDA(c_hlda),
        .HOLD(c_hold), .GNT(c_gnt), .OWNER(c_owner), .BUS_LOST(c_lost));

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       hlda;
        logic       hold;
        logic [1:0] gnt;
        logic       owner;
        logic       lost;
    } vec_t;

    vec_t vecs[39];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int rst, input int req, input int hlda,
                                input int hold, input int gnt, input int own, input int lost);
        vec_t v;
        v.rst   = rst[0];
        v.req   = req[1:0];
        v.hlda  = hlda[0];
        v.hold  = hold[0];
        v.gnt   = gnt[1:0];
        v.owner = own[0];
        v.lost  = lost[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e4;
        logic [1:0] e2;
        int         ow;

        a_rst = 1'b1; a_req = '0; a_hlda = 1'b0;
        b_rst = 1'b1; b_req = '0; b_hlda = 1'b0;
        c_rst = 1'b1; c_req = '0; c_hlda = 1'b0;

        //            rst req    hlda  hold gnt   own lost
        vecs[0]  = mk(1, 2'b00, 0,    0, 2'b00, 0, 0);
        vecs[1]  = mk(0, 2'b01, 0,    1, 2'b00, 0, 0);
        vecs[2]  = mk(0, 2'b01, 0,    1, 2'b00, 0, 0);
        vecs[3]  = mk(0, 2'b01, 1,    1, 2'b01, 0, 0);
        vecs[4]  = mk(0, 2'b01, 1,    1, 2'b01, 0, 0);
        vecs[5]  = mk(0, 2'b00, 1,    0, 2'b00, 0, 0);
        vecs[6]  = mk(0, 2'b00, 1,    0, 2'b00, 0, 0);
        vecs[7]  = mk(0, 2'b00, 0,    0, 2'b00, 0, 0);
        vecs[8]  = mk(1, 2'b00, 0,    0, 2'b00, 0, 0);
        vecs[9]  = mk(0, 2'b11, 0,    1, 2'b00, 0, 0);
        vecs[10] = mk(0, 2'b11, 1,    1, 2'b01, 0, 0);
        vecs[11] = mk(0, 2'b10, 1,    1, 2'b00, 0, 0);
        vecs[12] = mk(0, 2'b10, 1,    1, 2'b10, 1, 0);
        vecs[13] = mk(0, 2'b10, 1,    1, 2'b10, 1, 0);
        vecs[14] = mk(0, 2'b00, 1,    0, 2'b00, 1, 0);
        vecs[15] = mk(0, 2'b00, 0,    0, 2'b00, 1, 0);
        vecs[16] = mk(0, 2'b01, 0,    1, 2'b00, 1, 0);
        vecs[17] = mk(0, 2'b01, 1,    1, 2'b01, 0, 0);
        vecs[18] = mk(0, 2'b01, 0,    0, 2'b00, 0, 1);
        vecs[19] = mk(0, 2'b01, 1,    0, 2'b00, 0, 0);
        vecs[20] = mk(0, 2'b01, 0,    0, 2'b00, 0, 0);
        vecs[21] = mk(0, 2'b01, 0,    1, 2'b00, 0, 0);
        vecs[22] = mk(0, 2'b01, 1,    1, 2'b01, 0, 0);
        vecs[23] = mk(0, 2'b00, 0,    0, 2'b00, 0, 1);
        vecs[24] = mk(0, 2'b00, 0,    0, 2'b00, 0, 0);
        vecs[25] = mk(0, 2'b01, 0,    1, 2'b00, 0, 0);
        vecs[26] = mk(0, 2'b00, 0,    0, 2'b00, 0, 0);
        vecs[27] = mk(0, 2'b00, 0,    0, 2'b00, 0, 0);
        vecs[28] = mk(0, 2'b10, 0,    1, 2'b00, 0, 0);
        vecs[29] = mk(0, 2'b10, 1,    1, 2'b10, 1, 0);
        vecs[30] = mk(1, 2'b10, 1,    0, 2'b00, 0, 0);
        vecs[31] = mk(0, 2'b01, 0,    1, 2'b00, 0, 0);
        vecs[32] = mk(0, 2'b01, 1,    1, 2'b01, 0, 0);
        vecs[33] = mk(0, 2'b11, 1,    1, 2'b01, 0, 0);
        vecs[34] = mk(0, 2'b10, 1,    1, 2'b00, 0, 0);
        vecs[35] = mk(1, 2'b10, 1,    0, 2'b00, 0, 0);
        vecs[36] = mk(0, 2'b11, 0,    1, 2'b00, 0, 0);
        vecs[37] = mk(0, 2'b11, 1,    1, 2'b01, 0, 0);
        vecs[38] = mk(1, 2'b00, 0,    0, 2'b00, 0, 0);

        for (int i = 0; i < 39; i++) begin
            a_rst  = vecs[i].rst;
            a_req  = vecs[i].req;
            a_hlda = vecs[i].hlda;
            tick();
            check($sformatf("v%0d_hold", i),  a_hold,  vecs[i].hold);
            check($sformatf("v%0d_gnt", i),   a_gnt,   vecs[i].gnt);
            check($sformatf("v%0d_owner", i), a_owner, vecs[i].owner);
            check($sformatf("v%0d_lost", i),  a_lost,  vecs[i].lost);
        end

        // Round-robin over four requesters, each dropping after two grant cycles.
        tick();
        check("rr_reset_gnt", b_gnt, 4'b0000);
        check("rr_reset_hold", b_hold, 1'b0);
        b_rst = 1'b0; b_req = 4'hF; b_hlda = 1'b0;
        tick();
        check("rr_hold", b_hold, 1'b1);
        b_hlda = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            ow = k % 4;
            e4 = 4'b0001 << ow;
            check($sformatf("rr%0d_gnt", k), b_gnt, e4);
            check($sformatf("rr%0d_owner", k), b_owner, ow);
            tick();
            check($sformatf("rr%0d_gnt2", k), b_gnt, e4);
            b_req = 4'hF & ~e4;
            tick();
            check($sformatf("rr%0d_gap", k), b_gnt, 4'b0000);
            check($sformatf("rr%0d_gap_hold", k), b_hold, 1'b1);
            check($sformatf("rr%0d_onehot", k), $onehot0(b_gnt), 1'b1);
            b_req = 4'hF;
            tick();
            check($sformatf("rr%0d_onehot2", k), $onehot0(b_gnt), 1'b1);
        end
        b_rst = 1'b1;

        // Tenure limit with two competing requesters.
        tick();
        c_rst = 1'b0; c_req = 2'b11; c_hlda = 1'b0;
        tick();
        c_hlda = 1'b1;
        tick();
        for (int t = 0; t < 14; t++) begin
`ifdef HOLD_TENURE_LIMIT_EN
            if ((t % 5) == 4)            e2 = 2'b00;
            else if (((t / 5) % 2) == 0) e2 = 2'b01;
            else                         e2 = 2'b10;
`else
            e2 = 2'b01;
`endif
            check($sformatf("ten%0d_gnt", t), c_gnt, e2);
            check($sformatf("ten%0d_hold", t), c_hold, 1'b1);
            tick();
        end

        // Lone requester keeps the bus past the tenure limit.
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0; c_req = 2'b01; c_hlda = 1'b0;
        tick();
        c_hlda = 1'b1;
        tick();
        for (int t = 0; t < 12; t++) begin
            check($sformatf("solo%0d_gnt", t), c_gnt, 2'b01);
            tick();
        end
        c_req = 2'b00;
        tick();
        check("solo_drop_gnt", c_gnt, 2'b00);
        check("solo_drop_hold", c_hold, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
